myriadrf_tx_sched: RTL and testbench

Burst scheduler for the MyriadRF transmit path, sitting between the TX sample source (DMA/FIFO stream) and myriadrf_tx_if. It starts and stops bursts under register control, meters a programmed number of 24-bit IQ samples into the interface, and substitutes a constant test word when test mode is selected. The interface consumes one sample on every second clock and ignores valid, so the scheduler always presents a defined sample: zeros when idle or when the source underruns. It counts underruns for software.

---
 rtl/myriadrf_pkg.sv | 24 ++
 rtl/myriadrf_sat_cnt.sv | 25 ++
 rtl/myriadrf_tx_sched.sv | 134 +++++++++++++
 tb/tb_myriadrf_tx_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/myriadrf_pkg.sv
// Shared MyriadRF definitions: state encoding, IQ width and IQ field slices.
// Used by the TX scheduler, myriadrf_tx_if and the RX path.
package myriadrf_pkg;

    localparam int IQ_W  = 24;
    localparam int I_MSB = 23;
    localparam int I_LSB = 12;
    localparam int Q_MSB = 11;
    localparam int Q_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic logic [IQ_W-1:0] iq_pack(
        input logic [I_MSB-I_LSB:0] i,
        input logic [Q_MSB-Q_LSB:0] q
    );
        return {i, q};
    endfunction

endpackage

// File: rtl/myriadrf_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear plus increment yields 1.
// Ports: clk, rst, clr, inc, cnt (W bits).
module myriadrf_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= {{(W-1){1'b0}}, inc};
        end else if (inc && cnt != MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/myriadrf_tx_sched.sv
// TX burst scheduler: meters IQ samples into myriadrf_tx_if on each load strobe.
// Ports: control (start/stop/len/test), stream in (s_*), sample out (m_*), status.
module myriadrf_tx_sched
    import myriadrf_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] burst_len_i,
    input  logic             test_mode_i,
    input  logic [IQ_W-1:0]  test_iq_i,
    input  logic             clr_i,
    input  logic [IQ_W-1:0]  s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [IQ_W-1:0]  m_data_o,
    input  logic             m_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             underrun_o,
    output logic [CNT_W-1:0] underrun_cnt_o
);

    state_t           state_q, state_n;
    logic [CNT_W-1:0] len_q, len_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             test_q, test_n;
    logic [IQ_W-1:0]  data_n;
    logic             done_n;
    logic             slot;
    logic             urun;
    logic             urun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            test_q   <= 1'b0;
            m_data_o <= '0;
            done_o   <= 1'b0;
            urun_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            len_q    <= len_n;
            cnt_q    <= cnt_n;
            test_q   <= test_n;
            m_data_o <= data_n;
            done_o   <= done_n;
            urun_q   <= urun | (urun_q & ~clr_i);
        end
    end

    always_comb begin
        state_n = state_q;
        len_n   = len_q;
        cnt_n   = cnt_q;
        test_n  = test_q;
        data_n  = m_data_o;
        done_n  = 1'b0;
        slot    = 1'b0;
        urun    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (m_ready_i) data_n = '0;
                if (start_i) begin
                    state_n = ST_ARM;
                    len_n   = burst_len_i;
                    test_n  = test_mode_i;
                    cnt_n   = '0;
                end
            end
            ST_ARM: begin
                if (stop_i) begin
                    state_n = ST_IDLE;
                    if (m_ready_i) data_n = '0;
                end else if (m_ready_i) begin
                    // Waiting for data here is not an underrun.
                    if (test_q || s_valid_i) begin
                        slot    = 1'b1;
                        data_n  = test_q ? test_iq_i : s_data_i;
                        cnt_n   = CNT_W'(1);
                        state_n = ST_RUN;
                    end else begin
                        data_n = '0;
                    end
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_n = ST_IDLE;
                    if (m_ready_i) data_n = '0;
                end else if (m_ready_i) begin
                    // Burst-end slot carries a zero, not a sample.
                    if (len_q != '0 && cnt_q == len_q) begin
                        data_n  = '0;
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        slot  = 1'b1;
                        cnt_n = cnt_q + 1'b1;
                        if (test_q) begin
                            data_n = test_iq_i;
                        end else if (s_valid_i) begin
                            data_n = s_data_i;
                        end else begin
                            data_n = '0;
                            urun   = 1'b1;
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign s_ready_o  = m_ready_i & ~test_q & s_valid_i & slot & ~rst;
    assign busy_o     = (state_q != ST_IDLE);
    assign underrun_o = urun_q;

    myriadrf_sat_cnt #(
        .W (CNT_W)
    ) u_urun_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_i),
        .inc (urun),
        .cnt (underrun_cnt_o)
    );

endmodule

// File: tb/tb_myriadrf_tx_sched.sv
// Directed bench for myriadrf_tx_sched: vector table plus multi-cycle sequences.
// Uses CNT_W=4 so counter saturation is reachable quickly.
module tb_myriadrf_tx_sched;

    localparam int CW = 4;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i, stop_i, test_mode_i, clr_i;
    logic [CW-1:0] burst_len_i;
    logic [DW-1:0] test_iq_i, s_data_i, m_data_o;
    logic          s_valid_i, s_ready_o, m_ready_i;
    logic          busy_o, done_o, underrun_o;
    logic [CW-1:0] underrun_cnt_o;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (done_o) done_seen <= done_seen + 1;

    myriadrf_tx_sched #(.CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .burst_len_i    (burst_len_i),
        .test_mode_i    (test_mode_i),
        .test_iq_i      (test_iq_i),
        .clr_i          (clr_i),
        .s_data_i       (s_data_i),
        .s_valid_i      (s_valid_i),
        .s_ready_o      (s_ready_o),
        .m_data_o       (m_data_o),
        .m_ready_i      (m_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .underrun_o     (underrun_o),
        .underrun_cnt_o (underrun_cnt_o)
    );

    typedef struct {
        logic          start;
        logic          mr;
        logic [DW-1:0] sd;
        logic [DW-1:0] e_data;
        logic          e_busy;
        logic          e_done;
        logic          e_srdy;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One load event followed by one idle cycle; returns s_ready at the load.
    task automatic ld(input logic v, input logic [DW-1:0] d,
                      output logic sr);
        m_ready_i = 1'b1;
        s_valid_i = v;
        s_data_i  = d;
        #1;
        sr = s_ready_o;
        cyc();
        m_ready_i = 1'b0;
        cyc();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic sr;
        int   d0;
        logic [DW-1:0] s [4];
        s[0] = 24'h001001; s[1] = 24'h002002;
        s[2] = 24'h003003; s[3] = 24'h004004;

        rst = 1'b1; start_i = 0; stop_i = 0; test_mode_i = 0; clr_i = 0;
        burst_len_i = '0; test_iq_i = '0; s_data_i = '0;
        s_valid_i = 0; m_ready_i = 0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_data", m_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ucnt", underrun_cnt_o, 0);
        chk("rst_uflag", underrun_o, 0);

        // Finite burst, len=4, upstream always valid.
        vt[0]  = '{1, 0, 24'h000000, 24'h000000, 0, 0, 0};
        vt[1]  = '{0, 1, 24'h001001, 24'h000000, 1, 0, 1};
        vt[2]  = '{0, 0, 24'h001001, 24'h001001, 1, 0, 0};
        vt[3]  = '{0, 1, 24'h002002, 24'h001001, 1, 0, 1};
        vt[4]  = '{0, 0, 24'h002002, 24'h002002, 1, 0, 0};
        vt[5]  = '{0, 1, 24'h003003, 24'h002002, 1, 0, 1};
        vt[6]  = '{0, 0, 24'h003003, 24'h003003, 1, 0, 0};
        vt[7]  = '{0, 1, 24'h004004, 24'h003003, 1, 0, 1};
        vt[8]  = '{0, 0, 24'h004004, 24'h004004, 1, 0, 0};
        vt[9]  = '{0, 1, 24'h005005, 24'h004004, 1, 0, 0};
        vt[10] = '{0, 0, 24'h005005, 24'h000000, 0, 1, 0};
        vt[11] = '{0, 1, 24'h005005, 24'h000000, 0, 0, 0};
        burst_len_i = 4'd4;
        s_valid_i   = 1'b1;
        d0 = done_seen;
        for (int i = 0; i < 12; i++) begin
            start_i   = vt[i].start;
            m_ready_i = vt[i].mr;
            s_data_i  = vt[i].sd;
            @(negedge clk);
            chk($sformatf("burst_data[%0d]", i), m_data_o, vt[i].e_data);
            chk($sformatf("burst_busy[%0d]", i), busy_o, vt[i].e_busy);
            chk($sformatf("burst_done[%0d]", i), done_o, vt[i].e_done);
            chk($sformatf("burst_srdy[%0d]", i), s_ready_o, vt[i].e_srdy);
            cyc();
        end
        start_i = 0; m_ready_i = 0;
        chk("burst_done_once", done_seen - d0, 1);
        chk("burst_ucnt", underrun_cnt_o, 0);

        // Underrun, len=6: S1 S2 0 0 S3 S4.
        burst_len_i = 4'd6;
        pulse_start();
        ld(1, s[0], sr); chk("ur_s1", m_data_o, s[0]);
        ld(1, s[1], sr); chk("ur_s2", m_data_o, s[1]);
        ld(0, s[2], sr); chk("ur_z1", m_data_o, 0);
        chk("ur_z1_srdy", sr, 0);
        ld(0, s[2], sr); chk("ur_z2", m_data_o, 0);
        ld(1, s[2], sr); chk("ur_s3", m_data_o, s[2]);
        ld(1, s[3], sr); chk("ur_s4", m_data_o, s[3]);
        ld(1, 24'h0AAAAA, sr); chk("ur_end", m_data_o, 0);
        chk("ur_end_srdy", sr, 0);
        chk("ur_busy", busy_o, 0);
        chk("ur_cnt", underrun_cnt_o, 2);
        chk("ur_flag", underrun_o, 1);
        clr_i = 1; cyc(); clr_i = 0;
        chk("ur_clr_cnt", underrun_cnt_o, 0);
        chk("ur_clr_flag", underrun_o, 0);

        // Test mode, len=3.
        test_mode_i = 1; test_iq_i = 24'h7FF800; burst_len_i = 4'd3;
        pulse_start();
        test_mode_i = 0;
        for (int i = 0; i < 3; i++) begin
            ld(1, 24'h123456, sr);
            chk($sformatf("tm_data[%0d]", i), m_data_o, 24'h7FF800);
            chk($sformatf("tm_srdy[%0d]", i), sr, 0);
        end
        ld(1, 24'h123456, sr);
        chk("tm_end", m_data_o, 0);
        chk("tm_busy", busy_o, 0);

        // Abort a continuous burst, then arm without data.
        burst_len_i = '0;
        pulse_start();
        ld(1, 24'h0A0A0A, sr);
        ld(1, 24'h0B0B0B, sr);
        chk("ab_data", m_data_o, 24'h0B0B0B);
        d0 = done_seen;
        pulse_stop();
        chk("ab_busy", busy_o, 0);
        ld(1, 24'h0C0C0C, sr);
        chk("ab_zero", m_data_o, 0);
        chk("ab_srdy", sr, 0);
        chk("ab_nodone", done_seen - d0, 0);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            ld(0, 24'h0D0D0D, sr);
            chk($sformatf("arm_data[%0d]", i), m_data_o, 0);
            chk($sformatf("arm_busy[%0d]", i), busy_o, 1);
        end
        chk("arm_ucnt", underrun_cnt_o, 0);
        pulse_stop();

        // Reset mid-burst.
        pulse_start();
        ld(1, 24'h0E0E0E, sr);
        ld(0, 24'h0, sr);
        chk("pre_rst_ucnt", underrun_cnt_o, 1);
        rst = 1; m_ready_i = 1; s_valid_i = 1;
        cyc();
        chk("mrst_data", m_data_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_done", done_o, 0);
        chk("mrst_ucnt", underrun_cnt_o, 0);
        chk("mrst_flag", underrun_o, 0);
        chk("mrst_srdy", s_ready_o, 0);
        rst = 0; m_ready_i = 0;

        // Saturation: 20 underruns with a 4-bit counter.
        pulse_start();
        ld(1, 24'h0F0F0F, sr);
        for (int i = 0; i < 20; i++) ld(0, 24'h0, sr);
        chk("sat_cnt", underrun_cnt_o, 15);
        pulse_stop();

        // Simultaneous events.
        start_i = 1; stop_i = 1; cyc();
        start_i = 0; stop_i = 0;
        chk("ss_idle_busy", busy_o, 1);
        start_i = 1; stop_i = 1; cyc();
        start_i = 0; stop_i = 0;
        chk("ss_busy_busy", busy_o, 0);
        pulse_start();
        ld(1, 24'h111111, sr);
        clr_i = 1; m_ready_i = 1; s_valid_i = 0;
        cyc();
        clr_i = 0; m_ready_i = 0;
        chk("clr_ur_cnt", underrun_cnt_o, 1);
        chk("clr_ur_flag", underrun_o, 1);
        pulse_stop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
